// File: rtl/seq_shift_unit_if.sv
// Operand, control and result bundle for seq_shift_unit.
// SEQ_SHIFT_ZERO_FLAG_EN adds the SHIFT_Zero result flag.
interface seq_shift_unit_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         ALU_FUN;
    logic [SHAMT_W-1:0] SHAMT;
    logic               Shift_Enable;
    logic [WIDTH-1:0]   SHIFT_OUT;
    logic               SHIFT_Carry;
    logic               SHIFT_Flag;
    logic               Busy;
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    logic               SHIFT_Zero;
`endif

    modport master (
        output A, B, ALU_FUN, SHAMT, Shift_Enable,
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        input  SHIFT_Zero,
`endif
        input  SHIFT_OUT, SHIFT_Carry, SHIFT_Flag, Busy
    );

    modport slave (
        input  A, B, ALU_FUN, SHAMT, Shift_Enable,
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        output SHIFT_Zero,
`endif
        output SHIFT_OUT, SHIFT_Carry, SHIFT_Flag, Busy
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: LSR/LSL/ASR/ROR, STEP bits per clock.
// SEQ_SHIFT_ZERO_FLAG_EN adds a registered result==0 flag.
module seq_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3,
    parameter int STEP    = 1
) (
    input  logic         CLK,
    input  logic         RST,
    seq_shift_unit_if.slave bus
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_LSL = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;
    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   op_sel;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   work_d;
    logic [SHAMT_W-1:0] count_q;
    logic [SHAMT_W-1:0] count_d;
    logic [1:0]         mode_q;
    logic               fill_q;
    logic               carry_q;
    logic               carry_d;
    logic [WIDTH-1:0]   out_q;
    logic               out_c_q;
    logic               flag_q;
    logic               busy;
    logic               start;
    logic               last;

    assign op_sel = bus.ALU_FUN[2] ? bus.B : bus.A;
    assign start  = (state_q == S_IDLE) && bus.Shift_Enable;
    assign last   = (state_q == S_SHIFT) && (count_q <= STEP_C);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state: leave IDLE on a start, return once count runs out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.Shift_Enable) state_d = S_SHIFT;
            S_SHIFT: if (count_q <= STEP_C) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        if (state_q == S_SHIFT) busy = 1'b1;
    end

    // One step: up to STEP single-bit moves, bounded by remaining count.
    always_comb begin
        work_d  = work_q;
        carry_d = carry_q;
        for (int i = 0; i < STEP; i++) begin
            if (SHAMT_W'(i) < count_q) begin
                unique case (mode_q)
                    M_LSR: begin
                        carry_d = work_d[0];
                        work_d  = {1'b0, work_d[WIDTH-1:1]};
                    end
                    M_LSL: begin
                        carry_d = work_d[WIDTH-1];
                        work_d  = {work_d[WIDTH-2:0], 1'b0};
                    end
                    M_ASR: begin
                        carry_d = work_d[0];
                        work_d  = {fill_q, work_d[WIDTH-1:1]};
                    end
                    M_ROR: begin
                        carry_d = work_d[0];
                        work_d  = {work_d[0], work_d[WIDTH-1:1]};
                    end
                    default: ;
                endcase
            end
        end
        count_d = (count_q > STEP_C) ? count_q - STEP_C : '0;
    end

    // Capture on start, step while shifting, publish on the last step.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            work_q  <= '0;
            count_q <= '0;
            mode_q  <= '0;
            fill_q  <= 1'b0;
            carry_q <= 1'b0;
            out_q   <= '0;
            out_c_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            flag_q <= 1'b0;
            if (start) begin
                work_q  <= op_sel;
                mode_q  <= bus.ALU_FUN[1:0];
                fill_q  <= op_sel[WIDTH-1];
                count_q <= bus.SHAMT;
                carry_q <= 1'b0;
            end else if (state_q == S_SHIFT) begin
                work_q  <= work_d;
                count_q <= count_d;
                carry_q <= carry_d;
                if (last) begin
                    out_q   <= work_d;
                    out_c_q <= carry_d;
                    flag_q  <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag refreshed with each published result.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)      zero_q <= 1'b0;
        else if (last) zero_q <= (work_d == '0);
    end

    assign bus.SHIFT_Zero = zero_q;
`endif

    assign bus.SHIFT_OUT   = out_q;
    assign bus.SHIFT_Carry = out_c_q;
    assign bus.SHIFT_Flag  = flag_q;
    assign bus.Busy        = busy;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: STEP=1 and STEP=2 instances in lockstep.
// Checks against a whole-shift arithmetic model.
module tb_seq_shift_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] a_d = '0;
    logic [7:0] b_d = '0;
    logic [2:0] fun_d = '0;
    logic [2:0] sh_d = '0;
    logic       en_d = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    seq_shift_unit_if #(.WIDTH(8), .SHAMT_W(3)) if1 ();
    seq_shift_unit_if #(.WIDTH(8), .SHAMT_W(3)) if2 ();

    assign if1.A = a_d;
    assign if1.B = b_d;
    assign if1.ALU_FUN = fun_d;
    assign if1.SHAMT = sh_d;
    assign if1.Shift_Enable = en_d;
    assign if2.A = a_d;
    assign if2.B = b_d;
    assign if2.ALU_FUN = fun_d;
    assign if2.SHAMT = sh_d;
    assign if2.Shift_Enable = en_d;

    seq_shift_unit #(.WIDTH(8), .SHAMT_W(3), .STEP(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(if1)
    );
    seq_shift_unit #(.WIDTH(8), .SHAMT_W(3), .STEP(2)) dut2 (
        .CLK(CLK), .RST(RST), .bus(if2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {carry, result} of a whole shift by s.
    function automatic logic [8:0] ref_shift(input logic [1:0] m,
                                             input logic [7:0] v,
                                             input int s);
        logic [15:0] w;
        logic [7:0]  r;
        logic        c;
        if (s == 0) return {1'b0, v};
        case (m)
            2'd0: begin r = v >> s; c = v[s-1]; end
            2'd1: begin w = {8'h00, v} << s; r = w[7:0]; c = w[8]; end
            2'd2: begin r = $signed(v) >>> s; c = v[s-1]; end
            default: begin w = {v, v} >> s; r = w[7:0]; c = v[s-1]; end
        endcase
        return {c, r};
    endfunction

    function automatic int lat(input int s, input int step);
        return (s == 0) ? 1 : (s + step - 1) / step;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_out1"}, if1.SHIFT_OUT, 0);
        chk({tag, "_cy1"}, if1.SHIFT_Carry, 0);
        chk({tag, "_flg1"}, if1.SHIFT_Flag, 0);
        chk({tag, "_bsy1"}, if1.Busy, 0);
        chk({tag, "_out2"}, if2.SHIFT_OUT, 0);
        chk({tag, "_flg2"}, if2.SHIFT_Flag, 0);
        chk({tag, "_bsy2"}, if2.Busy, 0);
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        chk({tag, "_z1"}, if1.SHIFT_Zero, 0);
`endif
    endtask

    // One op on both units; inputs scrambled once accepted.
    task automatic run_op(input string tag, input logic [2:0] fun,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sh, input bit hold);
        logic [7:0] op;
        logic [8:0] r;
        int l1;
        int l2;
        op = fun[2] ? b : a;
        r  = ref_shift(fun[1:0], op, int'(sh));
        l1 = lat(int'(sh), 1);
        l2 = lat(int'(sh), 2);
        @(negedge CLK);
        a_d = a; b_d = b; fun_d = fun; sh_d = sh; en_d = 1'b1;
        for (int n = 0; n <= l1; n++) begin
            @(negedge CLK);
            if (!hold || n >= l2) en_d = 1'b0;
            a_d = 8'($urandom);
            b_d = 8'($urandom);
            fun_d = 3'($urandom);
            sh_d = 3'($urandom);
            chk({tag, "_bsy1"}, if1.Busy, (n < l1));
            chk({tag, "_flg1"}, if1.SHIFT_Flag, (n == l1));
            chk({tag, "_bsy2"}, if2.Busy, (n < l2));
            chk({tag, "_flg2"}, if2.SHIFT_Flag, (n == l2));
            if (n >= l1) begin
                chk({tag, "_out1"}, if1.SHIFT_OUT, r[7:0]);
                chk({tag, "_cy1"}, if1.SHIFT_Carry, r[8]);
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
                chk({tag, "_z1"}, if1.SHIFT_Zero, (r[7:0] == 0));
`endif
            end
            if (n >= l2) begin
                chk({tag, "_out2"}, if2.SHIFT_OUT, r[7:0]);
                chk({tag, "_cy2"}, if2.SHIFT_Carry, r[8]);
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
                chk({tag, "_z2"}, if2.SHIFT_Zero, (r[7:0] == 0));
`endif
            end
        end
        en_d = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        en_d = 1'b0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_zero("rst");
        RST = 1'b1;

        run_op("lsr", 3'b000, 8'hB4, 8'h00, 3'd3, 1'b0);
        chk("lsr_lit", if1.SHIFT_OUT, 8'h16);
        chk("lsr_lit_cy", if1.SHIFT_Carry, 1);
        run_op("asr", 3'b010, 8'h90, 8'h00, 3'd2, 1'b0);
        chk("asr_lit", if1.SHIFT_OUT, 8'hE4);
        run_op("ror", 3'b011, 8'h81, 8'h00, 3'd1, 1'b0);
        chk("ror_lit", if1.SHIFT_OUT, 8'hC0);
        run_op("lslb", 3'b101, 8'h00, 8'h0F, 3'd7, 1'b0);
        chk("lslb_lit", if1.SHIFT_OUT, 8'h80);
        run_op("step2", 3'b001, 8'h01, 8'h00, 3'd5, 1'b0);
        chk("step2_lit", if2.SHIFT_OUT, 8'h20);
        run_op("zero", 3'b001, 8'h80, 8'h00, 3'd1, 1'b0);
        chk("zero_lit_cy", if1.SHIFT_Carry, 1);
        run_op("sh0", 3'b000, 8'h5A, 8'h00, 3'd0, 1'b0);
        chk("sh0_lit", if1.SHIFT_OUT, 8'h5A);

        // Enable held high: next accept only one cycle after done.
        @(negedge CLK);
        a_d = 8'hFF; fun_d = 3'b000; sh_d = 3'd6; en_d = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            @(negedge CLK);
            chk("hold_bsy", if1.Busy, (n != 6));
            chk("hold_flg", if1.SHIFT_Flag, (n == 6));
            if (n == 6) chk("hold_out", if1.SHIFT_OUT, 8'h03);
        end
        do_reset();
        check_zero("rst2");

        // Produce nonzero outputs, then reset mid-op.
        run_op("pre", 3'b000, 8'h5A, 8'h00, 3'd0, 1'b0);
        @(negedge CLK);
        a_d = 8'hC3; fun_d = 3'b000; sh_d = 3'd5; en_d = 1'b1;
        @(negedge CLK);
        en_d = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_zero("midrst");
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            if (n == 2) RST = 1'b1;
            chk("midrst_flg1", if1.SHIFT_Flag, 0);
            chk("midrst_flg2", if2.SHIFT_Flag, 0);
        end
        run_op("post", 3'b010, 8'hC3, 8'h00, 3'd5, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op("rnd", 3'($urandom), 8'($urandom), 8'($urandom),
                   3'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
